// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin trigger/measure sequencer for ultrasonic
// rangefinders. Each sensor in turn gets a trigger pulse. The scheduler then
// times the width of its echo pulse and reports the result, and finally
// waits out a guard gap before the next sensor is triggered.
module sonar_scheduler #(
  parameter int NUM_SENSORS    = 3,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GUARD_CYCLES   = 500_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic [31:0]            dist_cycles,
  output logic [1:0]             dist_id,
  output logic                   dist_valid,
  output logic                   timeout,
  output logic                   sweep_done,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GUARD
  } state_t;

  // Terminal counts for the shared counter in each timed state.
  localparam logic [31:0] TRIG_LAST  = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] MEAS_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);
  localparam logic [1:0]  IDX_LAST   = 2'(NUM_SENSORS - 1);

  // Echo synchronizer chain plus one delayed copy for edge detection.
  logic [NUM_SENSORS-1:0] echo_meta_reg;
  logic [NUM_SENSORS-1:0] echo_s_reg;
  logic [NUM_SENSORS-1:0] echo_d_reg;

  // Sequencer state.
  state_t                 state_reg, state_next;
  logic [1:0]             idx_reg, idx_next;
  logic [31:0]            cnt_reg, cnt_next;
  logic [NUM_SENSORS-1:0] trig_reg, trig_next;
  logic                   busy_reg;

  // Result registers.
  logic [31:0]            dist_cycles_reg;
  logic [1:0]             dist_id_reg;
  logic                   dist_valid_reg;
  logic                   timeout_reg;
  logic                   sweep_done_reg;

  // Report decision produced by the state logic.
  logic                   report_valid;
  logic [31:0]            report_dist;
  logic                   report_tmo;

  // Per-sensor selection masks for the current and the upcoming index.
  logic [NUM_SENSORS-1:0] sel_cur;
  logic [NUM_SENSORS-1:0] sel_next;
  logic                   rise_sel;
  logic                   level_sel;

  for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sel
    assign sel_cur[gi]  = (idx_reg == 2'(gi));
    assign sel_next[gi] = (idx_next == 2'(gi));
  end

  // Only the selected sensor's synchronized line is looked at.
  assign rise_sel  = |(sel_cur & echo_s_reg & ~echo_d_reg);
  assign level_sel = |(sel_cur & echo_s_reg);

  // Bring the raw echo lines into the clock domain and keep a delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta_reg <= '0;
      echo_s_reg    <= '0;
      echo_d_reg    <= '0;
    end else begin
      echo_meta_reg <= echo;
      echo_s_reg    <= echo_meta_reg;
      echo_d_reg    <= echo_s_reg;
    end
  end

  // Next-state, counter and report decision for the sensor sequence.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg + 32'd1;
    report_valid = 1'b0;
    report_dist  = '0;
    report_tmo   = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (en) begin
          state_next = TRIG;
        end
      end
      TRIG: begin
        if (cnt_reg == TRIG_LAST) begin
          state_next = WAIT_RISE;
          cnt_next   = '0;
        end
      end
      WAIT_RISE: begin
        if (rise_sel) begin
          // The edge cycle itself is the first high cycle of the pulse,
          // so the measurement starts already holding a count of one.
          state_next = MEASURE;
          cnt_next   = 32'd1;
        end else if (cnt_reg == WAIT_LAST) begin
          report_valid = 1'b1;
          report_tmo   = 1'b1;
          state_next   = GUARD;
          cnt_next     = '0;
        end
      end
      MEASURE: begin
        if (!level_sel) begin
          report_valid = 1'b1;
          report_dist  = cnt_reg;
          state_next   = GUARD;
          cnt_next     = '0;
        end else if (cnt_reg == MEAS_LIMIT) begin
          report_valid = 1'b1;
          report_dist  = MEAS_LIMIT;
          report_tmo   = 1'b1;
          state_next   = GUARD;
          cnt_next     = '0;
        end
      end
      GUARD: begin
        if (cnt_reg == GUARD_LAST) begin
          idx_next   = (idx_reg == IDX_LAST) ? 2'd0 : idx_reg + 2'd1;
          state_next = en ? TRIG : IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Trigger line is registered from the upcoming state so it is glitch-free.
  assign trig_next = (state_next == TRIG) ? sel_next : '0;

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      trig_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      trig_reg  <= trig_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  // Capture each result; values hold until the next report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_cycles_reg <= '0;
      dist_id_reg     <= '0;
      timeout_reg     <= 1'b0;
      dist_valid_reg  <= 1'b0;
      sweep_done_reg  <= 1'b0;
    end else begin
      dist_valid_reg <= report_valid;
      sweep_done_reg <= report_valid && (idx_reg == IDX_LAST);
      if (report_valid) begin
        dist_cycles_reg <= report_dist;
        dist_id_reg     <= idx_reg;
        timeout_reg     <= report_tmo;
      end
    end
  end

  assign trig        = trig_reg;
  assign busy        = busy_reg;
  assign dist_cycles = dist_cycles_reg;
  assign dist_id     = dist_id_reg;
  assign dist_valid  = dist_valid_reg;
  assign timeout     = timeout_reg;
  assign sweep_done  = sweep_done_reg;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Bench for sonar_scheduler. It runs directed echo scenarios and checks them
// against a procedural reference model on every clock, and it also checks a
// set of hand-computed literal results.
module tb_sonar_scheduler;

  localparam int NS   = 3;
  localparam int TRC  = 4;
  localparam int TOC  = 100;
  localparam int GDC  = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [NS-1:0] echo;
  logic [NS-1:0] trig;
  logic [31:0]   dist_cycles;
  logic [1:0]    dist_id;
  logic          dist_valid;
  logic          timeout;
  logic          sweep_done;
  logic          busy;

  int errors = 0;
  int checks = 0;

  sonar_scheduler #(
    .NUM_SENSORS   (NS),
    .TRIG_CYCLES   (TRC),
    .TIMEOUT_CYCLES(TOC),
    .GUARD_CYCLES  (GDC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .echo       (echo),
    .trig       (trig),
    .dist_cycles(dist_cycles),
    .dist_id    (dist_id),
    .dist_valid (dist_valid),
    .timeout    (timeout),
    .sweep_done (sweep_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected outputs after each rising edge, built from the behavioural rules:
  // the echo is seen through two sampling stages, a pulse is timed by counting
  // its high cycles, and each phase lasts a fixed number of cycles.
  logic [NS-1:0] exp_trig;
  logic [31:0]   exp_dist;
  logic [1:0]    exp_id;
  logic          exp_valid, exp_tmo, exp_sweep, exp_busy;
  logic [NS-1:0] m_s1, m_es, m_ed;
  logic          p_en;
  bit            m_rst;
  int            m_idx;

  task automatic step();
    @(posedge clk);
    p_en = en;
    m_ed = m_es;
    m_es = m_s1;
    m_s1 = echo;
    if (rst_n !== 1'b1) m_rst = 1'b1;
  endtask

  task automatic sensor(output bit cont);
    int  width;
    bit  tmo;
    bit  found;
    cont     = 1'b0;
    exp_busy = 1'b1;
    exp_trig = NS'(1 << m_idx);
    repeat (TRC) begin
      step();
      if (m_rst) return;
    end
    exp_trig = '0;
    found    = 1'b0;
    for (int c = 0; c < TOC; c++) begin
      if (m_es[m_idx] && !m_ed[m_idx]) begin
        found = 1'b1;
        break;
      end
      if (c != TOC - 1) begin
        step();
        if (m_rst) return;
      end
    end
    width = 0;
    tmo   = 1'b1;
    if (found) begin
      width = 1;
      forever begin
        step();
        if (m_rst) return;
        if (!m_es[m_idx]) begin
          tmo = 1'b0;
          break;
        end
        if (width == TOC) begin
          tmo = 1'b1;
          break;
        end
        width++;
      end
    end
    step();
    if (m_rst) return;
    exp_valid = 1'b1;
    exp_dist  = 32'(width);
    exp_id    = 2'(m_idx);
    exp_tmo   = tmo;
    exp_sweep = (m_idx == NS - 1);
    for (int g = 0; g < GDC; g++) begin
      step();
      if (m_rst) return;
      exp_valid = 1'b0;
      exp_sweep = 1'b0;
    end
    m_idx = (m_idx + 1) % NS;
    if (p_en) begin
      cont = 1'b1;
    end else begin
      exp_busy = 1'b0;
    end
  endtask

  task automatic run_model();
    bit cont;
    forever begin
      exp_busy = 1'b0;
      exp_trig = '0;
      do begin
        step();
        if (m_rst) return;
      end while (!p_en);
      do begin
        sensor(cont);
        if (m_rst) return;
      end while (cont);
    end
  endtask

  initial begin
    forever begin
      m_rst = 1'b0; m_idx = 0;
      m_s1 = '0; m_es = '0; m_ed = '0;
      exp_trig = '0; exp_dist = '0; exp_id = '0;
      exp_valid = 1'b0; exp_tmo = 1'b0; exp_sweep = 1'b0; exp_busy = 1'b0;
      wait (rst_n === 1'b1);
      run_model();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("cyc_trig", 32'(trig), 32'(exp_trig));
      check("cyc_busy", 32'(busy), 32'(exp_busy));
      check("cyc_dist_valid", 32'(dist_valid), 32'(exp_valid));
      check("cyc_sweep_done", 32'(sweep_done), 32'(exp_sweep));
      check("cyc_dist_cycles", dist_cycles, exp_dist);
      check("cyc_dist_id", 32'(dist_id), 32'(exp_id));
      check("cyc_timeout", 32'(timeout), 32'(exp_tmo));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Negedges until any trigger is seen; 'seen' is the trigger pattern.
  task automatic wait_trig(input string name, output logic [NS-1:0] seen, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (trig == '0 && n < 500);
    seen = trig;
    if (trig == '0) begin
      checks++; errors++;
      $display("FAIL %s: got no trigger, required one within 500 cycles", name);
    end
  endtask

  // Counts negedges while a trigger is high; returns once it has dropped.
  task automatic trig_width(input string name, output int w);
    w = 0;
    while (trig != '0 && w < 500) begin
      w++;
      @(negedge clk);
    end
    if (trig != '0) begin
      checks++; errors++;
      $display("FAIL %s: got trigger stuck high, required it to fall", name);
    end
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dist_valid && n < 500);
    if (!dist_valid) begin
      checks++; errors++;
      $display("FAIL %s: got no dist_valid, required one within 500 cycles", name);
    end
  endtask

  initial begin
    logic [NS-1:0] seen;
    int n;
    int w;
    rst_n = 1'b0; en = 1'b0; echo = '0;
    nclk(3);
    check("rst_trig", 32'(trig), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_dist_cycles", dist_cycles, 0);
    check("rst_dist_valid", 32'(dist_valid), 0);
    rst_n = 1'b1; en = 1'b1;

    // Sensor 0: 37-cycle echo.
    wait_trig("s0_trig_wait", seen, n);
    check("s0_trig_sel", 32'(seen), 32'(3'b001));
    trig_width("s0_trig_fall", w);
    check("s0_trig_width", w, 4);
    nclk(5);
    echo[0] = 1'b1; nclk(37); echo[0] = 1'b0;
    wait_valid("s0_valid_wait", n);
    check("s0_latency", n, 3);
    check("s0_dist", dist_cycles, 37);
    check("s0_id", 32'(dist_id), 0);
    check("s0_tmo", 32'(timeout), 0);
    check("s0_sweep", 32'(sweep_done), 0);

    // Sensor 1: no echo, wait-rise timeout.
    wait_trig("s1_trig_wait", seen, n);
    check("s1_trig_sel", 32'(seen), 32'(3'b010));
    trig_width("s1_trig_fall", w);
    wait_valid("s1_valid_wait", n);
    check("s1_timeout_delay", n, 100);
    check("s1_dist", dist_cycles, 0);
    check("s1_id", 32'(dist_id), 1);
    check("s1_tmo", 32'(timeout), 1);

    // Sensor 2: echo stuck high, width timeout and sweep end.
    wait_trig("s2_trig_wait", seen, n);
    check("s2_trig_sel", 32'(seen), 32'(3'b100));
    trig_width("s2_trig_fall", w);
    nclk(3);
    echo[2] = 1'b1;
    wait_valid("s2_valid_wait", n);
    check("s2_dist", dist_cycles, 100);
    check("s2_tmo", 32'(timeout), 1);
    check("s2_sweep", 32'(sweep_done), 1);
    check("s2_id", 32'(dist_id), 2);
    wait_trig("s2_next_trig", seen, n);
    check("s2_next_sel", 32'(seen), 32'(3'b001));
    check("s2_guard_len", n, 10);
    echo[2] = 1'b0;

    // Sensor 0 again: 12-cycle echo; then pre-raise echo[1].
    trig_width("s0b_trig_fall", w);
    nclk(2);
    echo[0] = 1'b1; nclk(12); echo[0] = 1'b0;
    wait_valid("s0b_valid_wait", n);
    check("s0b_dist", dist_cycles, 12);
    echo[1] = 1'b1;

    // Sensor 1: line already high, neighbours toggling.
    wait_trig("s1b_trig_wait", seen, n);
    check("s1b_trig_sel", 32'(seen), 32'(3'b010));
    trig_width("s1b_trig_fall", w);
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) begin
        echo[0] = ~echo[0];
        echo[2] = ~echo[2];
      end
      @(negedge clk);
    end
    echo[0] = 1'b0; echo[2] = 1'b0;
    wait_valid("s1b_valid_wait", n);
    check("s1b_timeout_delay", n, 60);
    check("s1b_dist", dist_cycles, 0);
    check("s1b_tmo", 32'(timeout), 1);
    echo[1] = 1'b0;

    // Sensor 2: echo exactly TIMEOUT cycles wide is still a valid width.
    wait_trig("s2b_trig_wait", seen, n);
    check("s2b_trig_sel", 32'(seen), 32'(3'b100));
    trig_width("s2b_trig_fall", w);
    nclk(2);
    echo[2] = 1'b1; nclk(100); echo[2] = 1'b0;
    wait_valid("s2b_valid_wait", n);
    check("s2b_latency", n, 3);
    check("s2b_dist", dist_cycles, 100);
    check("s2b_tmo", 32'(timeout), 0);
    check("s2b_sweep", 32'(sweep_done), 1);

    // Sensor 0: en dropped mid-measurement.
    wait_trig("s0c_trig_wait", seen, n);
    check("s0c_trig_sel", 32'(seen), 32'(3'b001));
    trig_width("s0c_trig_fall", w);
    nclk(3);
    echo[0] = 1'b1; nclk(10); en = 1'b0; nclk(10); echo[0] = 1'b0;
    wait_valid("s0c_valid_wait", n);
    check("s0c_dist", dist_cycles, 20);
    check("s0c_tmo", 32'(timeout), 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    check("s0c_guard_to_idle", n, 10);
    nclk(30);
    check("s0c_idle_trig", 32'(trig), 0);
    check("s0c_idle_busy", 32'(busy), 0);
    en = 1'b1;
    wait_trig("s1c_trig_wait", seen, n);
    check("s1c_trig_sel", 32'(seen), 32'(3'b010));
    check("s1c_start_delay", n, 1);

    // Reset pulse during the trigger.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_trig", 32'(trig), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_dist_cycles", dist_cycles, 0);
    check("arst_timeout", 32'(timeout), 0);
    nclk(3);
    rst_n = 1'b1;
    wait_trig("post_rst_trig_wait", seen, n);
    check("post_rst_trig_sel", 32'(seen), 32'(3'b001));
    trig_width("post_rst_trig_fall", w);
    check("post_rst_trig_width", w, 4);
    nclk(2);
    echo[0] = 1'b1; nclk(5); echo[0] = 1'b0;
    wait_valid("post_rst_valid_wait", n);
    check("post_rst_dist", dist_cycles, 5);
    check("post_rst_id", 32'(dist_id), 0);
    nclk(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
